// File: rtl/transpose_feeder_pkg.sv
// Shared types and constants for the transposer feeder.
package transpose_feeder_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    PREFILL,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/transpose_feeder_fifo.sv
// Small prefetch FIFO whose head is held in a register, so dout only moves on a
// pop or when the first word lands in an empty FIFO.
module feeder_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_next;

  assign rd_next = rd_ptr + PW'(1);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // A pop with a single entry left takes a simultaneous push straight into the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_next;
      count <= count + CW'(push) - CW'(pop);
      if (pop) begin
        if (count > CW'(1)) dout <= mem[rd_next];
        else if (push)      dout <= din;
      end else if (empty && push) begin
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/transpose_feeder.sv
// Fetches words from a 1-cycle-latency source RAM into a prefetch FIFO and
// streams them into data_transposer under its busy/mvu_wr_en flow control.
module transpose_feeder
  import transpose_feeder_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int SRC_ADDR_LEN  = 12,
  parameter int MVU_ADDR_LEN  = 15,
  parameter int MAX_DATA_PREC = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [SRC_ADDR_LEN-1:0] cmd_src_addr,
  input  logic [15:0]             cmd_len,
  input  logic [31:0]             cmd_prec,
  input  logic [31:0]             cmd_baddr,
  output logic                    mem_rd_en,
  output logic [SRC_ADDR_LEN-1:0] mem_rd_addr,
  input  logic [XLEN-1:0]         mem_rd_data,
  output logic [31:0]             xp_prec,
  output logic [31:0]             xp_baddr,
  output logic [XLEN-1:0]         xp_iword,
  output logic                    xp_start,
  input  logic                    xp_busy,
  input  logic                    xp_mvu_wr_en,
  output logic                    done,
  output logic                    err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MVU_ADDR_LEN > 32
      || SRC_ADDR_LEN > LEN_W) begin : g_bad_params
    $error("transpose_feeder: unsupported parameter combination");
  end

  feeder_state_t state, next_state;

  logic [SRC_ADDR_LEN-1:0] src_addr;
  logic [LEN_W-1:0]        job_len, issued, fetched, consumed;
  logic                    inflight, push, pop, accept, underflow;
  logic                    credit_ok, cmd_take, bad_prec, active;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_full, fifo_empty;
  logic [XLEN-1:0]         fifo_head;

  assign cmd_take  = (state == IDLE) && cmd_valid;
  assign bad_prec  = (cmd_prec == 32'd0) || (cmd_prec > 32'(MAX_DATA_PREC));
  assign active    = (state == PREFILL) || (state == STREAM);
  // Reserve a FIFO slot for the word already on the RAM bus before issuing another read.
  assign credit_ok = ({1'b0, fifo_count} + {{CW{1'b0}}, inflight}) < (CW + 1)'(FIFO_DEPTH);
  assign mem_rd_en   = active && (issued < job_len) && credit_ok;
  assign mem_rd_addr = src_addr + issued[SRC_ADDR_LEN-1:0];
  assign push      = active && inflight;
  assign cmd_ready = (state == IDLE);
  assign xp_start  = (state == STREAM);
  assign done      = (state == DONE);
  assign accept    = xp_start && !xp_busy && !xp_mvu_wr_en;
  assign pop       = accept && !fifo_empty;
  assign underflow = accept && fifo_empty;
  assign xp_iword  = xp_start ? fifo_head : '0;

  feeder_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (mem_rd_data),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Prefill ends on the edge that completes the FIFO or the job, so streaming starts immediately after.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0 || bad_prec) next_state = DONE;
          else                           next_state = PREFILL;
        end
      end
      PREFILL: begin
        if (fifo_full || (push && fifo_count == CW'(FIFO_DEPTH - 1))
            || (fetched + LEN_W'(push) == job_len))
          next_state = STREAM;
      end
      STREAM: begin
        if (underflow || (pop && consumed == job_len - LEN_W'(1))) next_state = DRAIN;
      end
      DRAIN: begin
        if (!xp_busy && !xp_mvu_wr_en) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_addr <= '0;
      job_len  <= '0;
      issued   <= '0;
      fetched  <= '0;
      consumed <= '0;
      inflight <= 1'b0;
      xp_prec  <= '0;
      xp_baddr <= '0;
      err      <= 1'b0;
    end else begin
      inflight <= mem_rd_en;
      err      <= (cmd_take && cmd_len != '0 && bad_prec) || underflow;
      if (cmd_take) begin
        src_addr <= cmd_src_addr;
        job_len  <= cmd_len;
        xp_prec  <= cmd_prec;
        xp_baddr <= cmd_baddr;
        issued   <= '0;
        fetched  <= '0;
        consumed <= '0;
      end else begin
        if (mem_rd_en) issued   <= issued + LEN_W'(1);
        if (push)      fetched  <= fetched + LEN_W'(1);
        if (pop)       consumed <= consumed + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_transpose_feeder.sv
// Directed, table-driven bench for transpose_feeder with a RAM model and a
// scripted transposer handshake.
module tb_transpose_feeder;

  typedef struct {
    logic [11:0] src;
    logic [15:0] len;
    logic [31:0] prec;
    logic [31:0] baddr;
    bit          stall;
    int          tail;
    int          exp_err;
    bit          exp_quick;
    int          exp_reads;
    int          exp_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [11:0] cmd_src_addr = '0;
  logic [15:0] cmd_len = '0;
  logic [31:0] cmd_prec = '0;
  logic [31:0] cmd_baddr = '0;
  logic        mem_rd_en;
  logic [11:0] mem_rd_addr;
  logic [31:0] mem_rd_data = '0;
  logic [31:0] xp_prec, xp_baddr, xp_iword;
  logic        xp_start;
  logic        xp_busy = 1'b0;
  logic        xp_mvu_wr_en = 1'b0;
  logic        done, err;

  logic [31:0] ram [4096];
  vec_t        vecs [7];

  int n_applied = 0;
  int n_miscompares = 0;

  int cyc = 0;
  bit clear_req = 1'b0;
  int done_cyc = -1, err_cyc = -1, err_cnt = 0;
  int first_rd = -1, first_start = -1, first_acc = -1, last_acc = -1;
  int max_occ = 0, stable_viol = 0, zero_viol = 0;
  bit start_seen = 1'b0, prev_hold = 1'b0;
  logic [31:0] prev_iword = '0;
  logic [11:0] addr_log [$];
  logic [31:0] word_log [$];

  transpose_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_src_addr (cmd_src_addr),
    .cmd_len      (cmd_len),
    .cmd_prec     (cmd_prec),
    .cmd_baddr    (cmd_baddr),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .xp_prec      (xp_prec),
    .xp_baddr     (xp_baddr),
    .xp_iword     (xp_iword),
    .xp_start     (xp_start),
    .xp_busy      (xp_busy),
    .xp_mvu_wr_en (xp_mvu_wr_en),
    .done         (done),
    .err          (err)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] exp_word(input logic [11:0] a);
    logic [11:0] off;
    off = a - 12'h010;
    return {20'd0, off} + 32'd1;
  endfunction

  // RAM model plus an observer that logs every read, accept and completion event.
  always @(posedge clk) begin
    bit acc;
    int occ;
    if (clear_req) begin
      addr_log.delete();
      word_log.delete();
      done_cyc = -1; err_cyc = -1; err_cnt = 0;
      first_rd = -1; first_start = -1; first_acc = -1; last_acc = -1;
      max_occ = 0; stable_viol = 0; zero_viol = 0;
      start_seen = 1'b0; prev_hold = 1'b0;
    end else begin
      if (mem_rd_en) begin
        addr_log.push_back(mem_rd_addr);
        if (first_rd < 0) first_rd = cyc;
      end
      if (xp_start) begin
        start_seen = 1'b1;
        if (first_start < 0) first_start = cyc;
      end
      acc = xp_start && !xp_busy && !xp_mvu_wr_en;
      if (acc) begin
        word_log.push_back(xp_iword);
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      if (xp_start && prev_hold && xp_iword !== prev_iword) stable_viol++;
      if (!xp_start && xp_iword !== 32'd0) zero_viol++;
      prev_hold  = xp_start && !acc;
      prev_iword = xp_iword;
      occ = addr_log.size() - word_log.size();
      if (occ > max_occ) max_occ = occ;
      if (done && done_cyc < 0) done_cyc = cyc;
      if (err) begin
        err_cnt++;
        if (err_cyc < 0) err_cyc = cyc;
      end
    end
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    cyc = cyc + 1;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_applied++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check_output({tag, "_mem_rd_en"}, 32'(mem_rd_en), 32'd0);
    check_output({tag, "_mem_rd_addr"}, 32'(mem_rd_addr), 32'd0);
    check_output({tag, "_xp_start"}, 32'(xp_start), 32'd0);
    check_output({tag, "_done"}, 32'(done), 32'd0);
    check_output({tag, "_err"}, 32'(err), 32'd0);
    check_output({tag, "_xp_iword"}, xp_iword, 32'd0);
    check_output({tag, "_xp_prec"}, xp_prec, 32'd0);
    check_output({tag, "_xp_baddr"}, xp_baddr, 32'd0);
  endtask

  task automatic apply_stimulus(input string tag, input vec_t v);
    int cmd_cyc, idle_cyc, guard, tail_left, exp_done;
    logic [11:0] ea;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req    = 1'b0;
    cmd_valid    = 1'b1;
    cmd_src_addr = v.src;
    cmd_len      = v.len;
    cmd_prec     = v.prec;
    cmd_baddr    = v.baddr;
    cmd_cyc      = cyc;
    idle_cyc     = -1;
    tail_left    = v.tail;
    guard        = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_output({tag, "_xp_prec"}, xp_prec, v.prec);
    check_output({tag, "_xp_baddr"}, xp_baddr, v.baddr);
    while (done_cyc < 0 && guard < 3000) begin
      if (!v.exp_quick && word_log.size() == int'(v.len)) begin
        xp_busy = 1'b0;
        if (tail_left > 0) begin
          xp_mvu_wr_en = 1'b1;
          tail_left--;
        end else begin
          xp_mvu_wr_en = 1'b0;
        end
        if (idle_cyc < 0 && !xp_mvu_wr_en) idle_cyc = cyc;
      end else begin
        xp_mvu_wr_en = 1'b0;
        xp_busy      = v.stall && ((cyc % 16) >= 8);
      end
      @(negedge clk);
      guard++;
    end
    xp_busy      = 1'b0;
    xp_mvu_wr_en = 1'b0;
    exp_done = v.exp_quick ? cmd_cyc + 1 : idle_cyc + 1;
    check_output({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    check_output({tag, "_cmd_ready_after"}, 32'(cmd_ready), 32'd1);
    check_output({tag, "_err_count"}, 32'(err_cnt), 32'(v.exp_err));
    if (v.exp_err != 0) check_output({tag, "_err_with_done"}, 32'(err_cyc), 32'(done_cyc));
    check_output({tag, "_reads"}, 32'(addr_log.size()), 32'(v.exp_reads));
    check_output({tag, "_accepts"}, 32'(word_log.size()), 32'(v.exp_reads));
    check_output({tag, "_start_seen"}, 32'(start_seen), 32'(v.exp_reads != 0));
    for (int i = 0; i < v.exp_reads && i < addr_log.size(); i++) begin
      ea = v.src + 12'(i);
      check_output($sformatf("%s_addr%0d", tag, i), 32'(addr_log[i]), 32'(ea));
    end
    for (int i = 0; i < v.exp_reads && i < word_log.size(); i++) begin
      ea = v.src + 12'(i);
      check_output($sformatf("%s_word%0d", tag, i), word_log[i], exp_word(ea));
    end
    if (v.exp_reads != 0) begin
      check_output({tag, "_cmd_to_read"}, 32'(first_rd - cmd_cyc), 32'd1);
      check_output({tag, "_read_to_start"}, 32'(first_start - first_rd), 32'(v.exp_lat));
      check_output({tag, "_occupancy_le4"}, 32'(max_occ <= 4), 32'd1);
      check_output({tag, "_iword_stable"}, 32'(stable_viol), 32'd0);
      check_output({tag, "_iword_zero_idle"}, 32'(zero_viol), 32'd0);
      if (!v.stall)
        check_output({tag, "_throughput"}, 32'(last_acc - first_acc), 32'(v.exp_reads - 1));
    end
  endtask

  initial begin
    vec_t post_rst;
    int guard;
    for (int a = 0; a < 4096; a++) ram[a] = exp_word(12'(a));

    //           src     len     prec   baddr        stall tail err quick reads lat
    vecs[0] = '{12'h010, 16'd64, 32'd8,  32'h0000_0000, 1'b0, 0, 0, 1'b0, 64, 5};
    vecs[1] = '{12'h010, 16'd64, 32'd8,  32'h0000_1234, 1'b1, 3, 0, 1'b0, 64, 5};
    vecs[2] = '{12'h010, 16'd0,  32'd8,  32'h0000_0000, 1'b0, 0, 0, 1'b1, 0,  0};
    vecs[3] = '{12'h010, 16'd5,  32'd0,  32'h0000_0011, 1'b0, 0, 1, 1'b1, 0,  0};
    vecs[4] = '{12'h010, 16'd5,  32'd17, 32'h0000_0022, 1'b0, 0, 1, 1'b1, 0,  0};
    vecs[5] = '{12'hFFE, 16'd4,  32'd16, 32'h0000_7FFF, 1'b0, 2, 0, 1'b0, 4,  5};
    vecs[6] = '{12'h100, 16'd3,  32'd1,  32'h0000_0040, 1'b0, 1, 0, 1'b0, 3,  4};
    post_rst = '{12'h020, 16'd2, 32'd4,  32'h0000_0009, 1'b0, 0, 0, 1'b0, 2,  3};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int k = 0; k < 7; k++) apply_stimulus($sformatf("v%0d", k), vecs[k]);

    // Abort a long job mid-stream with rst, then confirm a fresh job still runs.
    clear_req = 1'b1;
    @(negedge clk);
    clear_req    = 1'b0;
    cmd_valid    = 1'b1;
    cmd_src_addr = 12'h010;
    cmd_len      = 16'd64;
    cmd_prec     = 32'd8;
    cmd_baddr    = 32'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (word_log.size() < 10 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check_output("abort_accepts", 32'(word_log.size()), 32'd10);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    @(negedge clk);
    check_output("abort_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
    check_output("abort_no_err", 32'(err_cnt), 32'd0);
    apply_stimulus("post_rst", post_rst);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule
